gshare_bpred: RTL and testbench
===============================

GSHARE_BPRED -- requirements
Module: gshare_bpred

Interface
REQ-001 SHALL have parameter PHT_ENTRIES, default 1024, pattern-history-table depth, power of two, 16..4096.
REQ-002 SHALL have parameter GHR_W, default 10, global-history width, 1..log2(PHT_ENTRIES).
REQ-003 SHALL have parameter BTB_ENTRIES, default 64, direct-mapped branch-target-buffer depth, power of two.
REQ-004 SHALL have parameter MODE, default 1, index mode: 0 = bimodal (PC only), 1 = gshare (PC xor GHR).
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: lkp_valid_i  in  1  fetch advancing this cycle (not stalled).
REQ-008 SHALL have ports: lkp_pc_i  in  32  fetch PC.
REQ-009 SHALL have ports: pred_taken_o  out  1  predicted taken (combinational from lkp_pc_i and state).
REQ-010 SHALL have ports: pred_target_o  out  32  predicted target, 0 when BTB misses.
REQ-011 SHALL have ports: pred_ghr_o  out  GHR_W  GHR snapshot used for this lookup, carried down the pipe.
REQ-012 SHALL have ports: upd_valid_i  in  1  resolved branch in execute, one pulse per branch.
REQ-013 SHALL have ports: upd_pc_i  in  32; upd_taken_i  in  1; upd_target_i  in  32; upd_mispred_i  in  1; upd_ghr_i  in  GHR_W.
REQ-014 SHALL have ports: perf_lookups_o  out  32; perf_mispred_o  out  32; both are statistics counters.

Function
REQ-015 SHALL compute PHT index as lkp_pc_i[log2(PHT_ENTRIES)+1:2], XORed with zero-extended GHR when MODE=1.
REQ-016 SHALL compute BTB index as pc[log2(BTB_ENTRIES)+1:2], with tag pc[31:log2(BTB_ENTRIES)+2]; hit = valid & tag match.
REQ-017 SHALL drive pred_taken_o = BTB hit & MSB of the indexed 2-bit saturating counter; zero-cycle latency.
REQ-018 SHALL, when lkp_valid_i & BTB hit & no mispredict recovery that cycle, shift pred_taken_o into GHR LSB.
REQ-019 SHALL, when upd_valid_i & upd_mispred_i, load GHR with {upd_ghr_i[GHR_W-2:0], upd_taken_i}, overriding any speculative shift that cycle.
REQ-020 SHALL, on upd_valid_i, update the counter at the index recomputed from upd_pc_i and upd_ghr_i: increment if taken (saturate 3), decrement if not (saturate 0).
REQ-021 SHALL, on upd_valid_i & upd_taken_i, write BTB entry {valid=1, tag, upd_target_i}; not-taken updates leave the BTB unchanged.
REQ-022 SHALL return pre-update (old) counter and BTB contents when lookup and update hit the same entry in the same cycle.
REQ-023 SHALL increment perf_lookups_o per lkp_valid_i and perf_mispred_o per upd_valid_i & upd_mispred_i, saturating at 32'hFFFF_FFFF.
REQ-024 SHALL ignore upd_mispred_i, upd_taken_i and upd_target_i when upd_valid_i=0.

Reset
REQ-025 SHALL, while reset=0, set all counters to 2'b01 (weakly not-taken), clear all BTB valid bits, and clear GHR and both perf counters.
REQ-026 SHALL hold pred_taken_o=0, pred_target_o=0 and pred_ghr_o=0 during reset; asserting reset mid-operation discards all history.

Structure
REQ-027 SHALL place the counter-init constant, the MODE encodings and the index/tag width helper functions in shared package bpred_pkg.
REQ-028 SHALL implement the BTB as sub-module bpred_btb (direct-mapped, one read port, one write port, async-reset valid bits).

Verification
REQ-029 SHALL cover: reset, then lookup PC 0x100 -> pred_taken_o=0, pred_target_o=0, pred_ghr_o=0.
REQ-030 SHALL cover: two taken updates at PC 0x100 with target 0x200 and GHR=0 (MODE=0) -> next lookup 0x100 gives taken=1, target=0x200.
REQ-031 SHALL cover: four not-taken updates at PC 0x100 -> counter saturates at 0 and no underflow; one taken update -> still predicts not-taken.
REQ-032 SHALL cover: MODE=1, GHR=10'h3FF, mispredict update with upd_ghr_i=10'h005, upd_taken_i=1, in the same cycle as a BTB-hit lookup -> GHR=10'h00B next cycle, speculative shift dropped.
REQ-033 SHALL cover: same-cycle lookup and taken update on PC 0x40 with an empty BTB -> this cycle pred_target_o=0; next cycle BTB hit.
REQ-034 SHALL cover: preload perf_mispred_o to 32'hFFFF_FFFE via force, then apply 3 mispredicts -> value 32'hFFFF_FFFF.

Source files
------------

// File: rtl/bpred_pkg.sv
// bpred_pkg: shared constants and index/tag width helpers for the gshare predictor
package bpred_pkg;
   localparam logic [1:0] CTR_INIT = 2'b01;
   localparam int MODE_BIMODAL = 0;
   localparam int MODE_GSHARE = 1;
   function automatic int idx_w(input int entries);
      return $clog2(entries);
   endfunction
   function automatic int tag_w(input int entries);
      return 30 - $clog2(entries);
   endfunction
endpackage

// File: rtl/gshare_bpred_if.sv
// gshare_bpred_if: fetch lookup, execute update and statistics signals of the branch predictor
//   master: fetch/execute side, drives lkp_* and upd_*, observes pred_* and perf_*
//   slave : predictor side
interface gshare_bpred_if #(
   parameter int GHR_W = 10
) ();
   logic             lkp_valid_i;
   logic [31:0]      lkp_pc_i;
   logic             pred_taken_o;
   logic [31:0]      pred_target_o;
   logic [GHR_W-1:0] pred_ghr_o;
   logic             upd_valid_i;
   logic [31:0]      upd_pc_i;
   logic             upd_taken_i;
   logic [31:0]      upd_target_i;
   logic             upd_mispred_i;
   logic [GHR_W-1:0] upd_ghr_i;
   logic [31:0]      perf_lookups_o;
   logic [31:0]      perf_mispred_o;
   modport master (
      output lkp_valid_i, lkp_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i, upd_ghr_i,
      input  pred_taken_o, pred_target_o, pred_ghr_o, perf_lookups_o, perf_mispred_o
   );
   modport slave (
      input  lkp_valid_i, lkp_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i, upd_ghr_i,
      output pred_taken_o, pred_target_o, pred_ghr_o, perf_lookups_o, perf_mispred_o
   );
endinterface

// File: rtl/bpred_btb.sv
// bpred_btb: direct-mapped branch target buffer, one combinational read port, one write port
//   clk, reset (async active-low) ; rd_pc_i/hit_o/target_o read port (target 0 on miss)
//   wr_en_i/wr_pc_i/wr_target_i write port ; pcs are word addresses (pc[31:2])
module bpred_btb import bpred_pkg::*; #(
   parameter int ENTRIES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] rd_pc_i,
   output logic        hit_o,
   output logic [31:0] target_o,
   input  logic        wr_en_i,
   input  logic [29:0] wr_pc_i,
   input  logic [31:0] wr_target_i
);
   localparam int BI = idx_w(ENTRIES);
   localparam int TW = tag_w(ENTRIES);
   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TW-1:0]      tag_q [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];
   logic [BI-1:0]      rd_idx, wr_idx;
   always_comb begin
      rd_idx = rd_pc_i[BI-1:0];
      wr_idx = wr_pc_i[BI-1:0];
      hit_o = valid_q[rd_idx] && tag_q[rd_idx] == rd_pc_i[29:BI];
      target_o = hit_o ? tgt_q[rd_idx] : '0;
      valid_d = valid_q;
      if (wr_en_i) valid_d[wr_idx] = 1'b1;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) valid_q <= '0;
      else valid_q <= valid_d;
   // Tag and target storage is qualified by the valid bits, so it needs no reset.
   always_ff @(posedge clk)
      if (wr_en_i) begin
         tag_q[wr_idx] <= wr_pc_i[29:BI];
         tgt_q[wr_idx] <= wr_target_i;
      end
endmodule

// File: rtl/gshare_bpred.sv
// gshare_bpred: gshare/bimodal direction predictor with BTB, speculative GHR and perf counters
//   clk, reset (async active-low) ; bp: lookup, update and statistics signals (slave side)
module gshare_bpred import bpred_pkg::*; #(
   parameter int PHT_ENTRIES = 1024,
   parameter int GHR_W = 10,
   parameter int BTB_ENTRIES = 64,
   parameter int MODE = 1
) (
   input logic           clk,
   input logic           reset,
   gshare_bpred_if.slave bp
);
   localparam int PI = idx_w(PHT_ENTRIES);
   logic [PHT_ENTRIES-1:0][1:0] pht_q, pht_d;
   logic [GHR_W-1:0]            ghr_q, ghr_d;
   logic [31:0]                 lookups_q, lookups_d, mispred_q, mispred_d;
   logic [PI-1:0]               lkp_idx, upd_idx;
   logic [1:0]                  ctr_old, ctr_new;
   logic                        btb_hit, pred_taken, recover;
   logic [31:0]                 btb_tgt;
   logic [3:0]                  unused_pc_lsbs;
   function automatic logic [PI-1:0] pht_idx(input logic [31:0] pc, input logic [GHR_W-1:0] ghr);
      return pc[PI+1:2] ^ (MODE == MODE_GSHARE ? PI'(ghr) : '0);
   endfunction
   bpred_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
      .clk(clk), .reset(reset),
      .rd_pc_i(bp.lkp_pc_i[31:2]), .hit_o(btb_hit), .target_o(btb_tgt),
      .wr_en_i(bp.upd_valid_i && bp.upd_taken_i), .wr_pc_i(bp.upd_pc_i[31:2]), .wr_target_i(bp.upd_target_i)
   );
   always_comb begin
      lkp_idx = pht_idx(bp.lkp_pc_i, ghr_q);
      upd_idx = pht_idx(bp.upd_pc_i, bp.upd_ghr_i);
      pred_taken = btb_hit && pht_q[lkp_idx][1];
      ctr_old = pht_q[upd_idx];
      ctr_new = bp.upd_taken_i ? (&ctr_old ? ctr_old : ctr_old + 2'd1) : (|ctr_old ? ctr_old - 2'd1 : ctr_old);
      pht_d = pht_q;
      if (bp.upd_valid_i) pht_d[upd_idx] = ctr_new;
      recover = bp.upd_valid_i && bp.upd_mispred_i;
      // A resolved mispredict rebuilds history from the branch's own snapshot and wins over speculation.
      ghr_d = recover ? GHR_W'({bp.upd_ghr_i, bp.upd_taken_i})
            : (bp.lkp_valid_i && btb_hit) ? GHR_W'({ghr_q, pred_taken}) : ghr_q;
      lookups_d = lookups_q + {31'd0, bp.lkp_valid_i && !(&lookups_q)};
      mispred_d = mispred_q + {31'd0, recover && !(&mispred_q)};
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pht_q <= {PHT_ENTRIES{CTR_INIT}};
         ghr_q <= '0;
         lookups_q <= '0;
         mispred_q <= '0;
      end else begin
         pht_q <= pht_d;
         ghr_q <= ghr_d;
         lookups_q <= lookups_d;
         mispred_q <= mispred_d;
      end
   assign bp.pred_taken_o = pred_taken;
   assign bp.pred_target_o = btb_tgt;
   assign bp.pred_ghr_o = ghr_q;
   assign bp.perf_lookups_o = lookups_q;
   assign bp.perf_mispred_o = mispred_q;
   assign unused_pc_lsbs = {bp.lkp_pc_i[1:0], bp.upd_pc_i[1:0]};
endmodule

// File: tb/tb_gshare_bpred.sv
// tb_gshare_bpred: directed tests of gshare_bpred, one bimodal and one gshare instance
module tb_gshare_bpred;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   gshare_bpred_if #(.GHR_W(10)) b0 ();
   gshare_bpred_if #(.GHR_W(10)) b1 ();
   gshare_bpred #(.PHT_ENTRIES(1024), .GHR_W(10), .BTB_ENTRIES(64), .MODE(0)) dut0 (.clk(clk), .reset(reset), .bp(b0.slave));
   gshare_bpred #(.PHT_ENTRIES(1024), .GHR_W(10), .BTB_ENTRIES(64), .MODE(1)) dut1 (.clk(clk), .reset(reset), .bp(b1.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b0.lkp_valid_i = 0; b0.lkp_pc_i = 0; b0.upd_valid_i = 0; b0.upd_pc_i = 0;
      b0.upd_taken_i = 0; b0.upd_target_i = 0; b0.upd_mispred_i = 0; b0.upd_ghr_i = 0;
      b1.lkp_valid_i = 0; b1.lkp_pc_i = 0; b1.upd_valid_i = 0; b1.upd_pc_i = 0;
      b1.upd_taken_i = 0; b1.upd_target_i = 0; b1.upd_mispred_i = 0; b1.upd_ghr_i = 0;
   endtask

   task automatic upd0(input logic [31:0] pc, input logic [31:0] tgt, input logic taken, input logic mis);
      b0.upd_valid_i = 1; b0.upd_pc_i = pc; b0.upd_target_i = tgt;
      b0.upd_taken_i = taken; b0.upd_mispred_i = mis; b0.upd_ghr_i = '0;
      tick();
      b0.upd_valid_i = 0;
   endtask

   task automatic upd1(input logic [31:0] pc, input logic [31:0] tgt, input logic taken, input logic mis, input logic [9:0] ghr);
      b1.upd_valid_i = 1; b1.upd_pc_i = pc; b1.upd_target_i = tgt;
      b1.upd_taken_i = taken; b1.upd_mispred_i = mis; b1.upd_ghr_i = ghr;
   endtask

   task automatic test_reset();
      idle();
      b0.lkp_pc_i = 32'h100;
      #2 reset = 1'b0;
      #8;
      checks++; if (b0.pred_taken_o !== 1'b0) begin failures++; $display("FAIL in_rst_taken got=%0h exp=0", b0.pred_taken_o); end
      checks++; if (b0.pred_target_o !== 32'h0) begin failures++; $display("FAIL in_rst_target got=%0h exp=0", b0.pred_target_o); end
      checks++; if (b1.pred_ghr_o !== 10'h0) begin failures++; $display("FAIL in_rst_ghr got=%0h exp=0", b1.pred_ghr_o); end
      #3 reset = 1'b1;
      tick();
      checks++; if (b0.pred_taken_o !== 1'b0) begin failures++; $display("FAIL rst_taken got=%0h exp=0", b0.pred_taken_o); end
      checks++; if (b0.pred_target_o !== 32'h0) begin failures++; $display("FAIL rst_target got=%0h exp=0", b0.pred_target_o); end
      checks++; if (b0.pred_ghr_o !== 10'h0) begin failures++; $display("FAIL rst_ghr got=%0h exp=0", b0.pred_ghr_o); end
      checks++; if (b0.perf_lookups_o !== 32'h0) begin failures++; $display("FAIL rst_lookups got=%0h exp=0", b0.perf_lookups_o); end
      checks++; if (b0.perf_mispred_o !== 32'h0) begin failures++; $display("FAIL rst_mispred got=%0h exp=0", b0.perf_mispred_o); end
   endtask

   task automatic test_train_taken();
      b0.lkp_pc_i = 32'h100;
      upd0(32'h100, 32'h200, 1, 0);
      upd0(32'h100, 32'h200, 1, 0);
      checks++; if (b0.pred_taken_o !== 1'b1) begin failures++; $display("FAIL train_taken got=%0h exp=1", b0.pred_taken_o); end
      checks++; if (b0.pred_target_o !== 32'h200) begin failures++; $display("FAIL train_target got=%0h exp=200", b0.pred_target_o); end
   endtask

   task automatic test_saturate_low();
      repeat (4) upd0(32'h100, 32'h0, 0, 0);
      checks++; if (b0.pred_taken_o !== 1'b0) begin failures++; $display("FAIL sat_nt_taken got=%0h exp=0", b0.pred_taken_o); end
      checks++; if (b0.pred_target_o !== 32'h200) begin failures++; $display("FAIL sat_nt_btb_kept got=%0h exp=200", b0.pred_target_o); end
      upd0(32'h100, 32'h200, 1, 0);
      checks++; if (b0.pred_taken_o !== 1'b0) begin failures++; $display("FAIL sat_underflow got=%0h exp=0", b0.pred_taken_o); end
   endtask

   task automatic test_lookup_count();
      b0.lkp_valid_i = 1; b0.lkp_pc_i = 32'h100;
      repeat (3) tick();
      b0.lkp_valid_i = 0;
      checks++; if (b0.perf_lookups_o !== 32'd3) begin failures++; $display("FAIL lookups got=%0d exp=3", b0.perf_lookups_o); end
      checks++; if (b0.pred_ghr_o !== 10'h0) begin failures++; $display("FAIL nt_shift_ghr got=%0h exp=0", b0.pred_ghr_o); end
   endtask

   task automatic test_same_cycle();
      b0.lkp_pc_i = 32'h40;
      b0.upd_valid_i = 1; b0.upd_pc_i = 32'h40; b0.upd_target_i = 32'h80;
      b0.upd_taken_i = 1; b0.upd_mispred_i = 0; b0.upd_ghr_i = '0;
      #1;
      checks++; if (b0.pred_target_o !== 32'h0) begin failures++; $display("FAIL same_cyc_target got=%0h exp=0", b0.pred_target_o); end
      checks++; if (b0.pred_taken_o !== 1'b0) begin failures++; $display("FAIL same_cyc_taken got=%0h exp=0", b0.pred_taken_o); end
      tick();
      b0.upd_valid_i = 0;
      #1;
      checks++; if (b0.pred_target_o !== 32'h80) begin failures++; $display("FAIL next_cyc_target got=%0h exp=80", b0.pred_target_o); end
      checks++; if (b0.pred_taken_o !== 1'b1) begin failures++; $display("FAIL next_cyc_taken got=%0h exp=1", b0.pred_taken_o); end
   endtask

   task automatic test_gshare_recover();
      upd1(32'h300, 32'h500, 1, 1, 10'h3FF);
      tick();
      b1.upd_valid_i = 0;
      checks++; if (b1.pred_ghr_o !== 10'h3FF) begin failures++; $display("FAIL load_ghr got=%0h exp=3ff", b1.pred_ghr_o); end
      b1.lkp_valid_i = 1; b1.lkp_pc_i = 32'h300;
      upd1(32'h704, 32'h900, 1, 1, 10'h005);
      #1;
      checks++; if (b1.pred_target_o !== 32'h500) begin failures++; $display("FAIL recov_hit_target got=%0h exp=500", b1.pred_target_o); end
      checks++; if (b1.pred_taken_o !== 1'b1) begin failures++; $display("FAIL recov_xor_taken got=%0h exp=1", b1.pred_taken_o); end
      tick();
      b1.upd_valid_i = 0;
      checks++; if (b1.pred_ghr_o !== 10'h00B) begin failures++; $display("FAIL recov_ghr got=%0h exp=00b", b1.pred_ghr_o); end
      checks++; if (b1.pred_taken_o !== 1'b0) begin failures++; $display("FAIL spec_taken got=%0h exp=0", b1.pred_taken_o); end
      tick();
      checks++; if (b1.pred_ghr_o !== 10'h016) begin failures++; $display("FAIL spec_shift_ghr got=%0h exp=016", b1.pred_ghr_o); end
      b1.lkp_pc_i = 32'h1000;
      tick();
      b1.lkp_valid_i = 0;
      checks++; if (b1.pred_ghr_o !== 10'h016) begin failures++; $display("FAIL miss_noshift_ghr got=%0h exp=016", b1.pred_ghr_o); end
      b1.lkp_pc_i = 32'h300;
      upd1(32'h300, 32'h500, 1, 0, 10'h016);
      tick();
      b1.upd_valid_i = 0;
      checks++; if (b1.pred_taken_o !== 1'b1) begin failures++; $display("FAIL gshare_idx_taken got=%0h exp=1", b1.pred_taken_o); end
      checks++; if (b1.pred_ghr_o !== 10'h016) begin failures++; $display("FAIL no_mis_ghr got=%0h exp=016", b1.pred_ghr_o); end
      b1.upd_valid_i = 0; b1.upd_mispred_i = 1; b1.upd_taken_i = 1; b1.upd_ghr_i = 10'h3FF;
      tick();
      b1.upd_mispred_i = 0;
      checks++; if (b1.pred_ghr_o !== 10'h016) begin failures++; $display("FAIL ignore_ghr got=%0h exp=016", b1.pred_ghr_o); end
      checks++; if (b1.perf_mispred_o !== 32'd2) begin failures++; $display("FAIL mispred_cnt got=%0d exp=2", b1.perf_mispred_o); end
   endtask

   task automatic test_perf_saturate();
      force dut0.mispred_q = 32'hFFFF_FFFE;
      upd0(32'h800, 32'h0, 0, 1);
      release dut0.mispred_q;
      upd0(32'h800, 32'h0, 0, 1);
      upd0(32'h800, 32'h0, 0, 1);
      checks++; if (b0.perf_mispred_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mispred_sat got=%0h exp=ffffffff", b0.perf_mispred_o); end
   endtask

   task automatic test_reset_mid();
      b0.lkp_pc_i = 32'h100;
      reset = 1'b0;
      #2;
      checks++; if (b1.pred_ghr_o !== 10'h0) begin failures++; $display("FAIL mid_rst_ghr got=%0h exp=0", b1.pred_ghr_o); end
      checks++; if (b0.pred_target_o !== 32'h0) begin failures++; $display("FAIL mid_rst_target got=%0h exp=0", b0.pred_target_o); end
      checks++; if (b0.perf_lookups_o !== 32'h0) begin failures++; $display("FAIL mid_rst_lookups got=%0h exp=0", b0.perf_lookups_o); end
      checks++; if (b0.perf_mispred_o !== 32'h0) begin failures++; $display("FAIL mid_rst_mispred got=%0h exp=0", b0.perf_mispred_o); end
      #1 reset = 1'b1;
      tick();
      checks++; if (b0.pred_target_o !== 32'h0) begin failures++; $display("FAIL post_rst_target got=%0h exp=0", b0.pred_target_o); end
      checks++; if (b0.pred_taken_o !== 1'b0) begin failures++; $display("FAIL post_rst_taken got=%0h exp=0", b0.pred_taken_o); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_train_taken();
      test_saturate_low();
      test_lookup_count();
      test_same_cycle();
      test_gshare_recover();
      test_perf_saturate();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
